// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the decode handoff.
// Master is the fetch unit; slave is the memory/decode environment facing it.
interface fetch_unit_if;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        imem_valid;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] stall_count;

   modport master (
      output imem_pc,
      input  imem_instr, imem_valid,
      input  redirect, redirect_pc,
      output out_valid, out_pc, out_instr,
      input  out_ready,
      output stall_count
   );

   modport slave (
      input  imem_pc,
      output imem_instr, imem_valid,
      output redirect, redirect_pc,
      input  out_valid, out_pc, out_instr,
      output out_ready,
      input  stall_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: holds the fetch PC, buffers {pc, instr} pairs in a
// small FIFO for decode, and reloads/flushes on branch redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

   logic [31:0]      pc_q;
   logic [31:0]      stall_q;
   logic [31:0]      buf_pc    [FIFO_DEPTH];
   logic [31:0]      buf_instr [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             deq;
   logic             enq;

   // A slot freed by this cycle's dequeue may be refilled in the same cycle.
   always_comb begin
      full = (count == DEPTH);
      deq  = (count != '0) & bus.out_ready;
      enq  = bus.imem_valid & ~bus.redirect & (~full | deq);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         stall_q <= '0;
      end else begin
         if (bus.redirect) begin
            pc_q   <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (enq) begin
               pc_q   <= pc_q + 32'd4;
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq)
               rd_ptr <= rd_ptr + 1'b1;
            if (enq & ~deq)
               count <= count + 1'b1;
            else if (deq & ~enq)
               count <= count - 1'b1;
         end
         if (~bus.redirect & ~enq & (stall_q != '1))
            stall_q <= stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         buf_pc[wr_ptr]    <= pc_q;
         buf_instr[wr_ptr] <= bus.imem_instr;
      end
   end

   assign bus.imem_pc     = pc_q;
   assign bus.out_valid   = (count != '0);
   assign bus.out_pc      = buf_pc[rd_ptr];
   assign bus.out_instr   = buf_instr[rd_ptr];
   assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns pc ^ KEY as the instruction word,
// and each task steps the clock by hand with precomputed expectations.
module tb_fetch_unit;
   localparam logic [31:0] KEY = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_instr = bus.imem_pc ^ KEY;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_valid  = 1'b0;
      bus.out_ready   = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset_stream();
      logic [31:0] exp;
      do_reset();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%h exp=%h", bus.out_valid, 1'b0); end
      checks++; if (bus.imem_pc !== 32'h0) begin failures++; $display("FAIL rst_imem_pc got=%h exp=%h", bus.imem_pc, 32'h0); end
      checks++; if (bus.stall_count !== 32'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=%0d", bus.stall_count, 0); end
      bus.imem_valid = 1'b0;
      tick();
      checks++; if (bus.imem_pc !== 32'h0) begin failures++; $display("FAIL bubble_imem_pc got=%h exp=%h", bus.imem_pc, 32'h0); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bubble_out_valid got=%h exp=%h", bus.out_valid, 1'b0); end
      checks++; if (bus.stall_count !== 32'd1) begin failures++; $display("FAIL bubble_stall got=%0d exp=%0d", bus.stall_count, 1); end
      bus.imem_valid = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         exp = 32'(4 * i);
         checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%h exp=%h", i, bus.out_valid, 1'b1); end
         checks++; if (bus.out_pc !== exp) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.out_pc, exp); end
         checks++; if (bus.out_instr !== (exp ^ KEY)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, bus.out_instr, exp ^ KEY); end
         checks++; if (bus.imem_pc !== exp + 32'd4) begin failures++; $display("FAIL stream_imem_pc[%0d] got=%h exp=%h", i, bus.imem_pc, exp + 32'd4); end
         tick();
      end
      checks++; if (bus.stall_count !== 32'd1) begin failures++; $display("FAIL stream_stall got=%0d exp=%0d", bus.stall_count, 1); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      do_reset();
      bus.out_ready  = 1'b0;
      bus.imem_valid = 1'b0;
      tick();
      bus.imem_valid = 1'b1;
      tick();
      tick();
      // Memory toggles valid while the PC is held on a full buffer.
      for (int k = 0; k < 6; k++) begin
         bus.imem_valid = (k % 2 == 0);
         tick();
         checks++; if (bus.imem_pc !== 32'h8) begin failures++; $display("FAIL hold_imem_pc[%0d] got=%h exp=%h", k, bus.imem_pc, 32'h8); end
         checks++; if (bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_head[%0d] got=%h/%h exp=%h/1", k, bus.out_pc, bus.out_valid, 32'h0); end
      end
      checks++; if (bus.stall_count !== 32'd7) begin failures++; $display("FAIL hold_stall got=%0d exp=%0d", bus.stall_count, 7); end
      bus.out_ready  = 1'b1;
      bus.imem_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         exp = 32'(4 * i);
         tick();
         checks++; if (bus.out_pc !== exp || bus.out_valid !== 1'b1) begin failures++; $display("FAIL release_pc[%0d] got=%h/%h exp=%h/1", i, bus.out_pc, bus.out_valid, exp); end
      end
      checks++; if (bus.stall_count !== 32'd7) begin failures++; $display("FAIL release_stall got=%0d exp=%0d", bus.stall_count, 7); end
   endtask

   task automatic test_redirect_full();
      do_reset();
      bus.out_ready  = 1'b0;
      bus.imem_valid = 1'b0;
      tick();
      bus.imem_valid = 1'b1;
      tick();
      tick();
      tick();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0100;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%h exp=%h", bus.out_valid, 1'b0); end
      checks++; if (bus.imem_pc !== 32'h100) begin failures++; $display("FAIL redir_imem_pc got=%h exp=%h", bus.imem_pc, 32'h100); end
      checks++; if (bus.stall_count !== 32'd2) begin failures++; $display("FAIL redir_stall got=%0d exp=%0d", bus.stall_count, 2); end
      bus.redirect   = 1'b0;
      bus.imem_valid = 1'b0;
      bus.out_ready  = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.imem_pc !== 32'h100) begin failures++; $display("FAIL redir_bubble got=%h/%h exp=0/%h", bus.out_valid, bus.imem_pc, 32'h100); end
      checks++; if (bus.stall_count !== 32'd3) begin failures++; $display("FAIL redir_bubble_stall got=%0d exp=%0d", bus.stall_count, 3); end
      bus.imem_valid = 1'b1;
      tick();
      checks++; if (bus.out_pc !== 32'h100 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL redir_first got=%h/%h exp=%h/1", bus.out_pc, bus.out_valid, 32'h100); end
      checks++; if (bus.out_instr !== (32'h100 ^ KEY)) begin failures++; $display("FAIL redir_first_instr got=%h exp=%h", bus.out_instr, 32'h100 ^ KEY); end
      tick();
      checks++; if (bus.out_pc !== 32'h104) begin failures++; $display("FAIL redir_second got=%h exp=%h", bus.out_pc, 32'h104); end
   endtask

   task automatic test_redirect_with_deq();
      do_reset();
      bus.imem_valid = 1'b0;
      tick();
      bus.imem_valid = 1'b1;
      tick();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0200;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rdeq_flush got=%h exp=%h", bus.out_valid, 1'b0); end
      checks++; if (bus.imem_pc !== 32'h200) begin failures++; $display("FAIL rdeq_imem_pc got=%h exp=%h", bus.imem_pc, 32'h200); end
      bus.redirect   = 1'b0;
      bus.imem_valid = 1'b0;
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.imem_pc !== 32'h200) begin failures++; $display("FAIL rdeq_no_stale got=%h/%h exp=0/%h", bus.out_valid, bus.imem_pc, 32'h200); end
      bus.imem_valid = 1'b1;
      tick();
      checks++; if (bus.out_pc !== 32'h200 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rdeq_first got=%h/%h exp=%h/1", bus.out_pc, bus.out_valid, 32'h200); end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] exp;
      bus.out_ready   = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFF8;
      tick();
      bus.redirect   = 1'b0;
      bus.imem_valid = 1'b0;
      tick();
      bus.imem_valid = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         exp = 32'hFFFF_FFF8 + 32'(4 * i);
         checks++; if (bus.out_pc !== exp || bus.out_valid !== 1'b1) begin failures++; $display("FAIL wrap_pc[%0d] got=%h/%h exp=%h/1", i, bus.out_pc, bus.out_valid, exp); end
         tick();
      end
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0103;
      tick();
      checks++; if (bus.imem_pc !== 32'h103) begin failures++; $display("FAIL misaligned_imem_pc got=%h exp=%h", bus.imem_pc, 32'h103); end
      bus.redirect   = 1'b0;
      bus.imem_valid = 1'b0;
      tick();
      bus.imem_valid = 1'b1;
      tick();
      checks++; if (bus.out_pc !== 32'h103) begin failures++; $display("FAIL misaligned_first got=%h exp=%h", bus.out_pc, 32'h103); end
      tick();
      checks++; if (bus.out_pc !== 32'h107) begin failures++; $display("FAIL misaligned_second got=%h exp=%h", bus.out_pc, 32'h107); end
   endtask

   task automatic test_reset_midstream();
      bus.out_ready   = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0040;
      tick();
      bus.redirect   = 1'b0;
      bus.imem_valid = 1'b0;
      tick();
      bus.imem_valid = 1'b1;
      tick();
      tick();
      tick();
      checks++; if (bus.imem_pc !== 32'h48 || bus.out_pc !== 32'h40) begin failures++; $display("FAIL mid_full got=%h/%h exp=%h/%h", bus.imem_pc, bus.out_pc, 32'h48, 32'h40); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%h exp=%h", bus.out_valid, 1'b0); end
      checks++; if (bus.imem_pc !== 32'h0) begin failures++; $display("FAIL mid_rst_imem_pc got=%h exp=%h", bus.imem_pc, 32'h0); end
      checks++; if (bus.stall_count !== 32'd0) begin failures++; $display("FAIL mid_rst_stall got=%0d exp=%0d", bus.stall_count, 0); end
      bus.imem_valid = 1'b0;
      bus.out_ready  = 1'b1;
      tick();
      checks++; if (bus.stall_count !== 32'd1) begin failures++; $display("FAIL mid_bubble_stall got=%0d exp=%0d", bus.stall_count, 1); end
      bus.imem_valid = 1'b1;
      tick();
      checks++; if (bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_restart0 got=%h/%h exp=%h/1", bus.out_pc, bus.out_valid, 32'h0); end
      tick();
      checks++; if (bus.out_pc !== 32'h4) begin failures++; $display("FAIL mid_restart1 got=%h exp=%h", bus.out_pc, 32'h4); end
   endtask

   initial begin
      rst             = 1'b1;
      bus.imem_valid  = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready   = 1'b1;
      test_reset_stream();
      test_backpressure();
      test_redirect_full();
      test_redirect_with_deq();
      test_pc_wrap();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
